dem_pn_generator: RTL

Pseudorandom bit source for the DEM DAC switching tree. It runs a Galois LFSR and advances it NUM_OUT steps per enabled clock, so that every switching block in the tree receives its own fresh, decorrelated 1-bit PN sequence (pn_seq_i) each cycle. It sits directly upstream of the switching blocks. It also provides software seed loading with a handshake, plus lock-up detection and recovery.

---
 rtl/dem_pn_generator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dem_pn_generator.sv
`default_nettype none
// ============================================================================
// Module      : dem_pn_generator
// Description : Galois LFSR PN source for the DEM switching tree; NUM_OUT
//               steps per advance, seed-load handshake, lock-up recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module dem_pn_generator #(
    parameter int unsigned                LFSR_LEN     = 16,
    parameter logic [LFSR_LEN-1:0]        TAPS         = 16'hB400,
    parameter int unsigned                NUM_OUT      = 7,
    parameter logic [LFSR_LEN-1:0]        DEFAULT_SEED = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [LFSR_LEN-1:0] seed_i,
    input  logic                seed_load_i,
    output logic                seed_ack_o,
    output logic [NUM_OUT-1:0]  pn_seq_o,
    output logic                pn_valid_o,
    output logic                lockup_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LFSR_LEN-1:0]   r_lfsr;
    logic [LFSR_LEN-1:0]   w_lfsr_next;
    logic [LFSR_LEN-1:0]   w_lfsr_adv;
    logic [LFSR_LEN-1:0]   w_step;
    logic [NUM_OUT-1:0]    r_pn;
    logic [NUM_OUT-1:0]    w_pn_next;
    logic [NUM_OUT-1:0]    w_pn_adv;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_ack;
    logic                  w_ack_next;
    logic                  r_lock;
    logic                  w_lock_next;
    logic                  w_zero;

    // NUM_OUT Galois steps unrolled; bit i is the output of step i.
    always_comb begin
        w_step   = r_lfsr;
        w_pn_adv = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_pn_adv[i] = w_step[0];
            w_step      = {1'b0, w_step[LFSR_LEN-1:1]} ^ (w_step[0] ? TAPS : '0);
        end
        w_lfsr_adv = w_step;
    end

    assign w_zero = (r_lfsr == '0);

    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_pn_next    = r_pn;
        w_valid_next = 1'b0;
        w_ack_next   = 1'b0;
        w_lock_next  = r_lock;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_RUN;
            end
            ST_RECOVER: begin
                w_lfsr_next  = DEFAULT_SEED;
                w_lock_next  = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_zero) begin
                    w_state_next = ST_RECOVER;
                end else if (seed_load_i) begin
                    w_ack_next = 1'b1;
                    // A zero seed would lock the LFSR, so substitute the default.
                    if (seed_i == '0) begin
                        w_lfsr_next = DEFAULT_SEED;
                        w_lock_next = 1'b1;
                    end else begin
                        w_lfsr_next = seed_i;
                    end
                end else if (enable_i) begin
                    w_lfsr_next  = w_lfsr_adv;
                    w_pn_next    = w_pn_adv;
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_lfsr  <= DEFAULT_SEED;
            r_pn    <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_pn    <= w_pn_next;
            r_valid <= w_valid_next;
            r_ack   <= w_ack_next;
            r_lock  <= w_lock_next;
        end
    end

    assign seed_ack_o = r_ack;
    assign pn_seq_o   = r_pn;
    assign pn_valid_o = r_valid;
    assign lockup_o   = r_lock;

endmodule
`default_nettype wire
